pipe_skid_reg: RTL
==================

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter DW, default 128, payload width in bits (minimum 1).
REQ-002 Parameter NOP_VAL, default all-zero DW-bit value, payload presented whenever the stage holds no valid entry.
REQ-003 Parameter SKID, default 1, selects mode: 1 = two-entry skid buffer, 0 = single-entry register.
REQ-004 ck_i  input  1  clock, all state updates on rising edge.
REQ-005 rs_n_i  input  1  reset, asynchronous, active-low.
REQ-006 flush_i  input  1  synchronous flush from control unit.
REQ-007 in_valid_i  input  1  upstream entry present.
REQ-008 in_data_i  input  DW  upstream payload.
REQ-009 in_ready_o  output  1  stage can accept an entry this cycle.
REQ-010 out_valid_o  output  1  downstream entry present.
REQ-011 out_data_o  output  DW  downstream payload.
REQ-012 out_ready_i  input  1  downstream consumes entry this cycle.
REQ-013 cnt_o  output  2  current occupancy (0..2).

Function
REQ-014 accept = in_valid_i & in_ready_o; drain = out_valid_o & out_ready_i; transfers occur only on those conditions.
REQ-015 Storage: main entry (drives out_data_o) and, when SKID=1, one skid entry; states EMPTY, ONE, FULL; out_valid_o = (state != EMPTY).
REQ-016 SKID=1: in_ready_o is a registered signal, 1 in EMPTY and ONE, 0 in FULL; it has no combinational path from out_ready_i.
REQ-017 SKID=1, EMPTY: accept -> ONE, main <= in_data_i.
REQ-018 SKID=1, ONE: accept & drain -> ONE, main <= in_data_i; accept & !drain -> FULL, skid <= in_data_i; drain & !accept -> EMPTY, main <= NOP_VAL; neither -> hold.
REQ-019 SKID=1, FULL: drain -> ONE, main <= skid, skid <= NOP_VAL; no drain -> hold.
REQ-020 SKID=0: in_ready_o = !out_valid_o | out_ready_i (combinational); states EMPTY/ONE only; accept -> main <= in_data_i; drain & !accept -> EMPTY, main <= NOP_VAL.
REQ-021 Latency: accepted entry appears on out_data_o with out_valid_o=1 on the cycle after acceptance when stage was EMPTY, or when stage was ONE with concurrent drain.
REQ-022 Ordering: entries leave in acceptance order; no entry duplicated or dropped except by flush.
REQ-023 out_data_o SHALL equal NOP_VAL whenever out_valid_o = 0.
REQ-024 Holding: with out_valid_o=1 and out_ready_i=0, out_data_o and out_valid_o remain stable.
REQ-025 Flush: flush_i=1 has priority over accept/drain; next state EMPTY, main and skid <= NOP_VAL, cnt_o <= 0; in_valid_i ignored that cycle (no accept counted even if in_ready_o=1).
REQ-026 cnt_o = 0/1/2 for EMPTY/ONE/FULL, registered.

Reset
REQ-027 rs_n_i=0 asynchronously forces state EMPTY, out_valid_o=0, out_data_o=NOP_VAL, skid=NOP_VAL, cnt_o=0, in_ready_o=1 (SKID=1).
REQ-028 Reset asserted mid-transfer discards all entries; first edge after release behaves as EMPTY.

Verification
REQ-029 SKID=1, DW=32: push 0xA1, 0xA2 on consecutive cycles with out_ready_i=0 -> cnt_o=2, in_ready_o=0, out_data_o=0xA1; raise out_ready_i -> 0xA1 then 0xA2 drain, cnt_o 1 then 0.
REQ-030 SKID=1: continuous in_valid_i=1, out_ready_i=1, data 1,2,3... -> one item per cycle, out_data_o lags input by one cycle, cnt_o stays 1.
REQ-031 Flush in FULL with in_valid_i=1, in_data_i=0x55 -> next cycle out_valid_o=0, out_data_o=NOP_VAL, cnt_o=0; 0x55 never appears.
REQ-032 SKID=0: out_ready_i=0 with entry held -> in_ready_o=0; out_ready_i=1 with in_valid_i=1, new data 0x77 -> 0x77 on out_data_o next cycle.
REQ-033 Assert rs_n_i low between clock edges while FULL -> outputs reach reset values immediately, without a clock edge.
REQ-034 Random valid/ready stimulus, 10k cycles, both SKID modes -> scoreboard shows in-order, lossless delivery; out_data_o=NOP_VAL whenever out_valid_o=0.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: one pipeline stage with valid/ready handshake on both sides.
//
// Handshake semantics (both ports): a transfer happens on a rising clock edge
// exactly when valid and ready are both high in that cycle. A producer that
// raises valid keeps its payload unchanged until the transfer happens, and
// ready never qualifies data on its own.
//
// Modes (SKID):
//   1 : two-entry skid buffer. in_ready_o comes straight from a flop, so no
//       combinational path runs from out_ready_i to in_ready_o.
//   0 : single-entry register. in_ready_o = !out_valid_o | out_ready_i.
//
// Ports:
//   ck_i        clock, rising edge
//   rs_n_i      asynchronous active-low reset
//   flush_i     synchronous flush; wins over accept and drain
//   in_valid_i  upstream entry present
//   in_data_i   upstream payload [DW-1:0]
//   in_ready_o  stage can accept an entry this cycle
//   out_valid_o downstream entry present
//   out_data_o  downstream payload; NOP_VAL whenever out_valid_o = 0
//   out_ready_i downstream consumes the entry this cycle
//   cnt_o       occupancy 0..2; this is the FSM state register itself,
//               so it doubles as the state debug view
module pipe_skid_reg #(
  parameter int            DW      = 128,
  parameter logic [DW-1:0] NOP_VAL = '0,
  parameter int            SKID    = 1
) (
  input  logic          ck_i,
  input  logic          rs_n_i,
  input  logic          flush_i,
  input  logic          in_valid_i,
  input  logic [DW-1:0] in_data_i,
  output logic          in_ready_o,
  output logic          out_valid_o,
  output logic [DW-1:0] out_data_o,
  input  logic          out_ready_i,
  output logic [1:0]    cnt_o
);

  // Encoding equals occupancy so cnt_o is a plain view of the state.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t        state_q, state_n;
  logic [DW-1:0] main_q, main_n;
  logic [DW-1:0] skid_q, skid_n;
  logic          rdy_q;
  logic          accept;
  logic          drain;

  assign out_valid_o = (state_q != EMPTY);
  // main is forced to NOP_VAL every time the stage empties, so the output
  // needs no extra mux.
  assign out_data_o  = main_q;
  assign cnt_o       = state_q;
  assign in_ready_o  = (SKID != 0) ? rdy_q : (!out_valid_o | out_ready_i);

  assign accept = in_valid_i & in_ready_o;
  assign drain  = out_valid_o & out_ready_i;

  always_comb begin
    state_n = state_q;
    main_n  = main_q;
    skid_n  = skid_q;
    if (flush_i) begin
      state_n = EMPTY;
      main_n  = NOP_VAL;
      skid_n  = NOP_VAL;
    end else if (SKID != 0) begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_n = ONE;
            main_n  = in_data_i;
          end
        end
        ONE: begin
          if (accept && drain) begin
            main_n = in_data_i;
          end else if (accept) begin
            state_n = FULL;
            skid_n  = in_data_i;
          end else if (drain) begin
            state_n = EMPTY;
            main_n  = NOP_VAL;
          end
        end
        FULL: begin
          // in_ready_o is low here, so only a drain can move the state.
          if (drain) begin
            state_n = ONE;
            main_n  = skid_q;
            skid_n  = NOP_VAL;
          end
        end
        default: begin
          state_n = EMPTY;
          main_n  = NOP_VAL;
          skid_n  = NOP_VAL;
        end
      endcase
    end else begin
      case (state_q)
        EMPTY, ONE: begin
          if (accept) begin
            state_n = ONE;
            main_n  = in_data_i;
          end else if (drain) begin
            state_n = EMPTY;
            main_n  = NOP_VAL;
          end
        end
        default: begin
          // FULL cannot be reached without the skid entry.
          state_n = EMPTY;
          main_n  = NOP_VAL;
          skid_n  = NOP_VAL;
        end
      endcase
    end
  end

  always_ff @(posedge ck_i or negedge rs_n_i) begin
    if (!rs_n_i) begin
      state_q <= EMPTY;
      main_q  <= NOP_VAL;
      skid_q  <= NOP_VAL;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_n;
      main_q  <= main_n;
      skid_q  <= skid_n;
      // Registered ready: high exactly when the next state leaves room.
      rdy_q   <= (state_n != FULL);
    end
  end

endmodule
